ad7606_emulator: RTL and testbench

AD7606_EMULATOR -- requirements
Module: ad7606_emulator

---
 rtl/ad7606_pkg.sv | 25 ++
 rtl/ad7606_emu_sync.sv | 35 +++
 rtl/ad7606_emulator.sv | 183 ++++++++++++++++++
 tb/tb_ad7606_emulator.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7606_pkg.sv
// Shared AD7606 definitions: FSM states, channel geometry and sample storage types.
package ad7606_pkg;

  localparam int unsigned AD_CH_NUM = 8;
  localparam int unsigned AD_DATA_W = 16;
  localparam int unsigned AD_PTR_W  = $clog2(AD_CH_NUM);
  localparam int unsigned AD_CNT_W  = 16;
  localparam int unsigned AD_ERR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_READY = 2'd2,
    ST_STBY  = 2'd3
  } ad_state_t;

  typedef logic [AD_DATA_W-1:0] ad_sample_t;
  typedef ad_sample_t [AD_CH_NUM-1:0] ad_samples_t;

  // Channel pointer increment with wrap after the last channel
  function automatic logic [AD_PTR_W-1:0] ad_next_ptr(input logic [AD_PTR_W-1:0] ptr);
    return (ptr == AD_PTR_W'(AD_CH_NUM - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/ad7606_emu_sync.sv
// Pin-input synchroniser with rise/fall pulses. Edges are only reported once every
// flop in the chain holds a pin-derived value, so reset contents never look like an edge.
module ad7606_emu_sync #(
  parameter int unsigned P_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [P_STAGES-1:0] sync_q;
  logic                edge_q;
  logic [P_STAGES:0]   vld_q;

  // Synchroniser chain, edge-detect register and chain-filled tracker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[P_STAGES-2:0], i_d};
      edge_q <= sync_q[P_STAGES-1];
      vld_q  <= {vld_q[P_STAGES-1:0], 1'b1};
    end
  end

  assign o_level  = sync_q[P_STAGES-1];
  assign o_rise_c = vld_q[P_STAGES] &  sync_q[P_STAGES-1] & ~edge_q;
  assign o_fall_c = vld_q[P_STAGES] & ~sync_q[P_STAGES-1] &  edge_q;

endmodule

// File: rtl/ad7606_emulator.sv
// AD7606 parallel-mode device emulator: convst-triggered sampling, busy timing and
// channel readout. Define AD7606_EMU_ERRCNT_EN to build the protocol error counter.
module ad7606_emulator
  import ad7606_pkg::*;
#(
  parameter int unsigned P_CONV_CYCLES = 200,
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_ad_convstA,
  input  logic                              i_ad_convstB,
  input  logic                              i_ad_reset,
  input  logic                              i_ad_cs,
  input  logic                              i_ad_rd,
  input  logic                              i_ad_sel,
  input  logic                              i_ad_stby,
  input  logic [AD_CH_NUM*AD_DATA_W-1:0]    i_smp_data,
  output logic                              o_ad_busy,
  output logic                              o_ad_firstdata,
  output logic [AD_DATA_W-1:0]              o_ad_data,
  output logic                              o_ad_data_oe,
  output logic                              o_conv_done,
  output logic [AD_ERR_W-1:0]               o_err_cnt
);

  localparam int unsigned PIN_N    = 7;
  localparam int unsigned PIN_CVA  = 0;
  localparam int unsigned PIN_CVB  = 1;
  localparam int unsigned PIN_RST  = 2;
  localparam int unsigned PIN_CS   = 3;
  localparam int unsigned PIN_RD   = 4;
  localparam int unsigned PIN_SEL  = 5;
  localparam int unsigned PIN_STBY = 6;

  logic [PIN_N-1:0] pin_raw;
  logic [PIN_N-1:0] pin_lvl;
  logic [PIN_N-1:0] pin_rise;
  logic [PIN_N-1:0] pin_fall;

  ad_state_t             state;
  ad_samples_t           samples;
  logic [AD_PTR_W-1:0]   ptr;
  logic [AD_CNT_W-1:0]   cnt;

  logic cva_rise_c;
  logic dev_rst_c;
  logic stby_c;
  logic sel_c;
  logic cs_n_c;
  logic rd_n_c;
  logic rd_rise_c;
  logic rd_access_c;
  logic unused_c;

  always_comb begin
    pin_raw           = '0;
    pin_raw[PIN_CVA]  = i_ad_convstA;
    pin_raw[PIN_CVB]  = i_ad_convstB;
    pin_raw[PIN_RST]  = i_ad_reset;
    pin_raw[PIN_CS]   = i_ad_cs;
    pin_raw[PIN_RD]   = i_ad_rd;
    pin_raw[PIN_SEL]  = i_ad_sel;
    pin_raw[PIN_STBY] = i_ad_stby;
  end

  // One synchroniser per device pin
  for (genvar g = 0; g < PIN_N; g++) begin : g_sync
    ad7606_emu_sync #(
      .P_STAGES (P_SYNC_STAGES)
    ) u_sync (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_d      (pin_raw[g]),
      .o_level  (pin_lvl[g]),
      .o_rise_c (pin_rise[g]),
      .o_fall_c (pin_fall[g])
    );
  end

  assign cva_rise_c  = pin_rise[PIN_CVA];
  assign dev_rst_c   = pin_lvl[PIN_RST];
  assign stby_c      = pin_lvl[PIN_STBY];
  assign sel_c       = pin_lvl[PIN_SEL];
  assign cs_n_c      = pin_lvl[PIN_CS];
  assign rd_n_c      = pin_lvl[PIN_RD];
  assign rd_rise_c   = pin_rise[PIN_RD];
  assign rd_access_c = (state == ST_READY) && !cs_n_c && !rd_n_c && !sel_c;

  // convstB and several edge pulses are synchronised but have no function in parallel mode
  assign unused_c = ^{pin_lvl, pin_rise, pin_fall};

  // Conversion FSM: reset > standby > per-state behaviour; busy and done are registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      samples     <= '0;
      ptr         <= '0;
      cnt         <= '0;
      o_ad_busy   <= 1'b0;
      o_conv_done <= 1'b0;
    end else begin
      o_conv_done <= 1'b0;
      if (dev_rst_c) begin
        state     <= ST_IDLE;
        samples   <= '0;
        ptr       <= '0;
        cnt       <= '0;
        o_ad_busy <= 1'b0;
      end else if (stby_c) begin
        state     <= ST_STBY;
        cnt       <= '0;
        o_ad_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_READY: begin
            if (cva_rise_c && !sel_c) begin
              state   <= ST_CONV;
              samples <= i_smp_data;
              ptr     <= '0;
              cnt     <= AD_CNT_W'(P_CONV_CYCLES);
            end else if (state == ST_READY && rd_rise_c && !cs_n_c) begin
              ptr <= ad_next_ptr(ptr);
            end
          end
          ST_CONV: begin
            if (cnt == '0) begin
              state       <= ST_READY;
              o_ad_busy   <= 1'b0;
              o_conv_done <= 1'b1;
            end else begin
              cnt       <= cnt - 1'b1;
              o_ad_busy <= 1'b1;
            end
          end
          ST_STBY: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Parallel read bus, one cycle behind the synchronised cs/rd access
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ad_data      <= '0;
      o_ad_data_oe   <= 1'b0;
      o_ad_firstdata <= 1'b0;
    end else begin
      o_ad_data      <= rd_access_c ? samples[ptr] : '0;
      o_ad_data_oe   <= rd_access_c;
      o_ad_firstdata <= rd_access_c && (ptr == '0);
    end
  end

`ifdef AD7606_EMU_ERRCNT_EN
  logic                bad_rd_c;
  logic                err_evt_c;
  logic [AD_ERR_W-1:0] err_cnt;

  // A misplaced read is counted once, when the cs/rd access begins
  assign bad_rd_c  = ((state == ST_IDLE) || (state == ST_CONV)) && !cs_n_c && !rd_n_c &&
                     (pin_fall[PIN_RD] || pin_fall[PIN_CS]);
  assign err_evt_c = !dev_rst_c && !stby_c &&
                     ((cva_rise_c && (sel_c || (state == ST_CONV))) || bad_rd_c);

  // Saturating protocol error counter, cleared by device reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt <= '0;
    end else if (dev_rst_c) begin
      err_cnt <= '0;
    end else if (err_evt_c && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ad7606_emulator.sv
// Randomised self-checking bench for ad7606_emulator against a transaction-level model.
`timescale 1ns/1ps
module tb_ad7606_emulator;

  localparam int unsigned CONV = 200;
  localparam int unsigned SYNC = 2;

  logic         clk;
  logic         rst_n;
  logic         convsta, convstb, ad_reset, cs, rd, sel, stby;
  logic [127:0] smp_data;
  logic         busy, first, oe, done;
  logic [15:0]  data;
  logic [7:0]   err;

  ad7606_emulator #(
    .P_CONV_CYCLES (CONV),
    .P_SYNC_STAGES (SYNC)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ad_convstA   (convsta),
    .i_ad_convstB   (convstb),
    .i_ad_reset     (ad_reset),
    .i_ad_cs        (cs),
    .i_ad_rd        (rd),
    .i_ad_sel       (sel),
    .i_ad_stby      (stby),
    .i_smp_data     (smp_data),
    .o_ad_busy      (busy),
    .o_ad_firstdata (first),
    .o_ad_data      (data),
    .o_ad_data_oe   (oe),
    .o_conv_done    (done),
    .o_err_cnt      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: latched samples, read pointer, error count
  logic [15:0] m_smp  [8];
  logic [15:0] m_next [8];
  int          m_ptr;
  int          m_err;
  int          n_chk;
  int          n_pass;
  int          done_seen;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_err();
`ifdef AD7606_EMU_ERRCNT_EN
    if (m_err < 255) m_err++;
`endif
  endtask

  task automatic load_data(input bit rnd);
    for (int k = 0; k < 8; k++) begin
      m_next[k] = rnd ? 16'($urandom) : 16'(16'h1000 + k);
      smp_data[16*k +: 16] = m_next[k];
    end
  endtask

  task automatic latch_model();
    for (int k = 0; k < 8; k++) m_smp[k] = m_next[k];
    m_ptr = 0;
  endtask

  // inj: 0 none, 1 convst pulse, 2 device reset, 3 cs/rd read; 'at' is the busy cycle
  task automatic run_conv(input bit pulse, input int lat_exp, input int inj, input int at,
                          output int blen, output logic dn);
    int k;
    if (pulse) begin
      convsta = 1'b0;
      tick(2);
      convsta = 1'b1;
    end
    k = 0;
    while (busy !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    chk("busy_latency", 32'(k), 32'(lat_exp));
    blen = 0;
    dn   = 1'b0;
    if (busy !== 1'b1) return;
    blen = 1;
    while (blen < 70000) begin
      if (blen == 1) smp_data = {$urandom, $urandom, $urandom, $urandom};
      if (inj == 1 && blen == at)     convsta  = 1'b0;
      if (inj == 1 && blen == at + 2) convsta  = 1'b1;
      if (inj == 2 && blen == at)     ad_reset = 1'b1;
      if (inj == 3 && blen == at)     begin cs = 1'b0; rd = 1'b0; end
      if (inj == 3 && blen == at + 2) rd = 1'b1;
      if (inj == 3 && blen == at + 3) cs = 1'b1;
      tick(1);
      if (busy === 1'b1) blen++;
      else break;
    end
    dn = done;
  endtask

  task automatic do_read(input bit exp_oe);
    logic        got, got_first;
    logic [15:0] got_data;
    cs = 1'b0;
    rd = 1'b0;
    tick(2);
    rd = 1'b1;
    got = 1'b0;
    got_first = 1'b0;
    got_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) cs = 1'b1;
      if (oe === 1'b1 && !got) begin
        got = 1'b1;
        got_data = data;
        got_first = first;
      end
      tick(1);
    end
    if (exp_oe) begin
      chk("read_oe", 32'(got), 32'd1);
      chk("read_data", 32'(got_data), 32'(m_smp[m_ptr]));
      chk("read_first", 32'(got_first), 32'(m_ptr == 0));
      m_ptr = (m_ptr + 1) % 8;
    end else begin
      chk("noread_oe", 32'(got), 32'd0);
      add_err();
    end
    chk("bus_idle", {15'd0, oe, data}, 32'd0);
  endtask

  task automatic nominal_conv(input bit rnd);
    int   len;
    logic dn;
    int   d0;
    load_data(rnd);
    d0 = done_seen;
    run_conv(1'b1, SYNC + 2, 0, 0, len, dn);
    latch_model();
    chk("busy_len", 32'(len), 32'(CONV));
    chk("done_at_fall", 32'(dn), 32'd1);
    tick(1);
    chk("done_count", 32'(done_seen - d0), 32'd1);
  endtask

  task automatic check_no_busy(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      if (busy === 1'b1) seen = 1'b1;
      tick(1);
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  int   len;
  logic dn;

  initial begin
    n_chk = 0; n_pass = 0; done_seen = 0;
    m_ptr = 0; m_err = 0;
    for (int k = 0; k < 8; k++) begin m_smp[k] = '0; m_next[k] = '0; end
    rst_n = 1'b0; convsta = 1'b1; convstb = 1'b1; ad_reset = 1'b0;
    cs = 1'b1; rd = 1'b1; sel = 1'b0; stby = 1'b0; smp_data = '0;
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_first", 32'(first), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    check_no_busy("no_spurious_conv", 12);

    // Nominal conversion and full readout with wrap
    nominal_conv(1'b0);
    chk("err_nominal", 32'(err), 32'(m_err));
    for (int i = 0; i < 9; i++) do_read(1'b1);

    // Random data, random number of reads
    for (int r = 0; r < 3; r++) begin
      nominal_conv(1'b1);
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) do_read(1'b1);
    end

    // Extra convst during busy
    load_data(1'b1);
    run_conv(1'b1, SYNC + 2, 1, 50, len, dn);
    latch_model();
    add_err();
    chk("busy_len_cvst", 32'(len), 32'(CONV));
    chk("err_cvst", 32'(err), 32'(m_err));
    do_read(1'b1);

    // Read attempt during conversion
    load_data(1'b1);
    run_conv(1'b1, SYNC + 2, 3, 80, len, dn);
    latch_model();
    add_err();
    chk("busy_len_rdconv", 32'(len), 32'(CONV));
    chk("err_rdconv", 32'(err), 32'(m_err));
    do_read(1'b1);

    // Device reset mid-conversion
    load_data(1'b1);
    run_conv(1'b1, SYNC + 2, 2, 100, len, dn);
    chk("busy_len_devrst", 32'(len), 32'(100 + SYNC));
    chk("done_devrst", 32'(dn), 32'd0);
    tick(2);
    ad_reset = 1'b0;
    tick(5);
    m_err = 0;
    m_ptr = 0;
    chk("err_devrst", 32'(err), 32'(m_err));
    do_read(1'b0);
    chk("err_idle_read", 32'(err), 32'(m_err));

    // Standby from READY swallows convst
    nominal_conv(1'b1);
    stby = 1'b1;
    tick(5);
    convsta = 1'b0;
    tick(2);
    convsta = 1'b1;
    check_no_busy("stby_no_busy", 12);
    stby = 1'b0;
    tick(5);
    chk("err_stby", 32'(err), 32'(m_err));
    do_read(1'b0);
    chk("err_after_stby", 32'(err), 32'(m_err));
    nominal_conv(1'b1);
    do_read(1'b1);

    // Serial select: convst ignored and flagged
    sel = 1'b1;
    tick(4);
    convsta = 1'b0;
    tick(2);
    convsta = 1'b1;
    check_no_busy("sel_no_busy", 12);
    add_err();
    sel = 1'b0;
    tick(4);
    chk("err_sel", 32'(err), 32'(m_err));

    // Same-cycle convst and rd rise in READY: conversion wins
    do_read(1'b1);
    do_read(1'b1);
    load_data(1'b1);
    cs = 1'b0; rd = 1'b0; convsta = 1'b0;
    tick(2);
    rd = 1'b1; convsta = 1'b1;
    tick(1);
    cs = 1'b1;
    run_conv(1'b0, SYNC + 1, 0, 0, len, dn);
    latch_model();
    chk("busy_len_race", 32'(len), 32'(CONV));
    do_read(1'b1);
    do_read(1'b1);

`ifdef AD7606_EMU_ERRCNT_EN
    // Error counter saturation
    sel = 1'b1;
    tick(4);
    for (int i = 0; i < 260; i++) begin
      convsta = 1'b0;
      tick(2);
      convsta = 1'b1;
      tick(3);
      add_err();
    end
    sel = 1'b0;
    tick(4);
    chk("err_saturate", 32'(err), 32'(m_err));
`endif

    // Asynchronous reset mid-conversion
    load_data(1'b1);
    convsta = 1'b0;
    tick(2);
    convsta = 1'b1;
    tick(SYNC + 20);
    chk("busy_before_rst", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_first", 32'(first), 32'd0);
    chk("arst_data", 32'(data), 32'd0);
    chk("arst_oe", 32'(oe), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    tick(2);
    rst_n = 1'b1;
    m_err = 0;
    m_ptr = 0;
    check_no_busy("no_spurious_conv2", 12);
    nominal_conv(1'b1);
    do_read(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
